// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB control/status block: register map,
// status/interrupt bit positions, reset values and the bus FSM state type.
package uart_apb_pkg;

  localparam logic [3:0] ADDR_MDR = 4'h0;
  localparam logic [3:0] ADDR_DLL = 4'h1;
  localparam logic [3:0] ADDR_DLH = 4'h2;
  localparam logic [3:0] ADDR_LCR = 4'h3;
  localparam logic [3:0] ADDR_IER = 4'h4;
  localparam logic [3:0] ADDR_FSR = 4'h5;
  localparam logic [3:0] ADDR_TBR = 4'h6;
  localparam logic [3:0] ADDR_RBR = 4'h7;
  localparam logic [3:0] ADDR_ISR = 4'h8;

  localparam int FSR_TX_FULL  = 0;
  localparam int FSR_TX_EMPTY = 1;
  localparam int FSR_RX_FULL  = 2;
  localparam int FSR_RX_EMPTY = 3;

  localparam int ISR_TX_EMPTY = 0;
  localparam int ISR_RX_AVAIL = 1;
  localparam int ISR_ERR      = 2;

  localparam logic [7:0] LCR_RESET = 8'h03;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } apb_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; pushes when full and
// pops when empty are ignored.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_apb_csr.sv
// APB3 control/status registers for the UART core with TX FIFO and RX stream.
// Optional interrupt status register and irq enabled by defining UART_IRQ_EN.
module uart_apb_csr
  import uart_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH   = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [7:0]            mdr,
  output logic [7:0]            dll,
  output logic [7:0]            dlh,
  output logic [7:0]            lcr,
  output logic [7:0]            ier,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  rx_full,
  output logic                  irq
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  apb_state_e       state_q, state_d;
  logic             access;
  logic [3:0]       addr;
  logic [7:0]       wdata8;
  logic [7:0]       mdr_q, mdr_d, dll_q, dll_d, dlh_q, dlh_d;
  logic [7:0]       lcr_q, lcr_d, ier_q, ier_d;
  logic [7:0]       prdata_q, rd8;
  logic             pslverr_q, err;
  logic             rx_ready_q, rx_pop;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [TX_CW-1:0] tx_count;
  logic [7:0]       fsr;
  logic             unused_bits;

`ifdef UART_IRQ_EN
  logic [2:0] isr_q, isr_d, isr_set, w1c;
  logic       rx_valid_q;
`endif

  assign addr   = PADDR[3:0];
  assign wdata8 = PWDATA[7:0];
  assign unused_bits = ^{PADDR, PWDATA, tx_count};

  assign fsr = {4'b0000, ~rx_valid, rx_full, tx_empty, tx_full};

  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: if (PSEL && PENABLE) begin
        state_d = ST_RESP;
        access  = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    mdr_d   = mdr_q;
    dll_d   = dll_q;
    dlh_d   = dlh_q;
    lcr_d   = lcr_q;
    ier_d   = ier_q;
    rd8     = '0;
    err     = 1'b0;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
`ifdef UART_IRQ_EN
    w1c     = '0;
`endif
    if (access) begin
      case (addr)
        ADDR_MDR: if (PWRITE) mdr_d = wdata8; else rd8 = mdr_q;
        ADDR_DLL: if (PWRITE) dll_d = wdata8; else rd8 = dll_q;
        ADDR_DLH: if (PWRITE) dlh_d = wdata8; else rd8 = dlh_q;
        ADDR_LCR: if (PWRITE) lcr_d = wdata8; else rd8 = lcr_q;
        ADDR_IER: if (PWRITE) ier_d = wdata8; else rd8 = ier_q;
        ADDR_FSR: if (PWRITE) err = 1'b1; else rd8 = fsr;
        // Full check uses the registered count, so a same-cycle pop does not help.
        ADDR_TBR: if (!PWRITE || tx_full) err = 1'b1; else tx_push = 1'b1;
        ADDR_RBR: if (PWRITE || !rx_valid) err = 1'b1;
                  else begin
                    rd8    = rx_data;
                    rx_pop = 1'b1;
                  end
`ifdef UART_IRQ_EN
        ADDR_ISR: if (PWRITE) w1c = wdata8[2:0]; else rd8 = {5'b00000, isr_q};
`endif
        default:  err = 1'b1;
      endcase
      if (err) rd8 = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= ST_IDLE;
      mdr_q      <= '0;
      dll_q      <= '0;
      dlh_q      <= '0;
      lcr_q      <= LCR_RESET;
      ier_q      <= '0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mdr_q      <= mdr_d;
      dll_q      <= dll_d;
      dlh_q      <= dlh_d;
      lcr_q      <= lcr_d;
      ier_q      <= ier_d;
      prdata_q   <= rd8;
      pslverr_q  <= err;
      rx_ready_q <= rx_pop;
    end
  end

  assign tx_pop   = tx_valid && tx_ready;
  assign tx_valid = !tx_empty;

  uart_sync_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRESETN),
    .push_i  (tx_push),
    .data_i  (wdata8),
    .pop_i   (tx_pop),
    .data_o  (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

`ifdef UART_IRQ_EN
  // Events are sticky and win over a same-cycle write-one-to-clear.
  always_comb begin
    isr_set               = '0;
    isr_set[ISR_TX_EMPTY] = tx_pop && !tx_push && (tx_count == TX_CW'(1));
    isr_set[ISR_RX_AVAIL] = rx_valid && !rx_valid_q;
    isr_set[ISR_ERR]      = err;
    isr_d                 = (isr_q & ~w1c) | isr_set;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      isr_q      <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      isr_q      <= isr_d;
      rx_valid_q <= rx_valid;
    end
  end

  assign irq = |(isr_q & ier_q[2:0]);
`else
  assign irq = 1'b0;
`endif

  assign PREADY   = (state_q == ST_RESP);
  assign PRDATA   = DATA_WIDTH'(prdata_q);
  assign PSLVERR  = pslverr_q;
  assign rx_ready = rx_ready_q;
  assign mdr      = mdr_q;
  assign dll      = dll_q;
  assign dlh      = dlh_q;
  assign lcr      = lcr_q;
  assign ier      = ier_q;

endmodule
